// File: rtl/render_pkg.sv
// Shared constants for the object render sequencer: FSM encodings and screen geometry.
package render_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_BLACK = 2'd3;

  localparam int unsigned SCREEN_X = 640;
  localparam int unsigned SCREEN_Y = 480;

  // A full-screen pass plus a small margin bounds any single phase.
  localparam int unsigned DEFAULT_TIMEOUT = SCREEN_X * SCREEN_Y + 16;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: flags the first cycle of a phase and the last allowed cycle.
module phase_timer
  import render_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic first,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign first   = (count_q == '0);
  assign expired = (count_q == LAST);

endmodule

// File: rtl/render_sequencer.sv
// Drives clear/draw/black phase levels into the object renderer, one pass per frame tick,
// with a forced black pass after reset or a goal, plus overrun and hang reporting.
module render_sequencer
  import render_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned OVR_W   = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             frameTick,
  input  logic             scored,
  input  logic             done_clearOld,
  input  logic             done_drawNew,
  input  logic             done_blackScreen,
  output logic             clearOld_pulse,
  output logic             drawNew_pulse,
  output logic             blackScreen_pulse,
  output logic             plot,
  output logic             frame_done,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_count,
  output logic             timeout_err
);

  logic [1:0]       state_q, state_d;
  logic             start_q;
  logic             pending_q, pending_d;
  logic             clr_q, drw_q, blk_q;
  logic             fd_q, fd_d;
  logic             err_q;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  logic in_phase, done_sel, done_ok, abort;
  logic first, expired, timer_clear, timer_run;

  assign in_phase = (state_q != S_IDLE);

  always_comb begin
    unique case (state_q)
      S_CLEAR: done_sel = done_clearOld;
      S_DRAW:  done_sel = done_drawNew;
      S_BLACK: done_sel = done_blackScreen;
      default: done_sel = 1'b0;
    endcase
  end

  // The first cycle of a phase ignores done so a stale flag cannot end the new phase.
  assign done_ok = in_phase & enable & ~first & done_sel;
  assign abort   = in_phase & enable & expired & ~done_ok;

  always_comb begin
    state_d = state_q;
    fd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_BLACK;
        end else if (frameTick && enable) begin
          state_d = pending_q ? S_BLACK : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (done_ok) begin
          state_d = S_DRAW;
        end else if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_DRAW, S_BLACK: begin
        if (done_ok) begin
          state_d = S_IDLE;
          fd_d    = 1'b1;
        end else if (abort) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entering black consumes the goal even if scored is still high on that edge;
  // an aborted black pass must be retried on the next tick.
  always_comb begin
    pending_d = pending_q;
    if ((state_d == S_BLACK) && (state_q != S_BLACK)) begin
      pending_d = 1'b0;
    end else if (scored || (abort && (state_q == S_BLACK))) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (frameTick && enable && in_phase && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  assign timer_clear = (state_d != state_q) || !in_phase;
  assign timer_run   = in_phase & enable;

  phase_timer #(
    .LIMIT (TIMEOUT)
  ) u_phase_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear),
    .run     (timer_run),
    .first   (first),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b1;
      pending_q <= 1'b0;
      clr_q     <= 1'b0;
      drw_q     <= 1'b0;
      blk_q     <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= 1'b0;
      pending_q <= pending_d;
      clr_q     <= (state_d == S_CLEAR);
      drw_q     <= (state_d == S_DRAW);
      blk_q     <= (state_d == S_BLACK);
      fd_q      <= fd_d;
      err_q     <= err_q | abort;
      ovr_q     <= ovr_d;
    end
  end

  assign clearOld_pulse    = clr_q;
  assign drawNew_pulse     = drw_q;
  assign blackScreen_pulse = blk_q;
  assign plot              = clr_q | drw_q | blk_q;
  assign frame_done        = fd_q;
  assign busy              = in_phase;
  assign overrun_count     = ovr_q;
  assign timeout_err       = err_q;

endmodule

// File: doc/render_sequencer.md
Name: render_sequencer

Overview:
- Initiator side of the object render handshake. Drives the clear-old / draw-new / black-screen phase levels into an object renderer and waits for its done flags.
- Sequences one clear-then-draw pass per frame tick.
- Inserts a full-screen black pass after reset and after any goal.
- Reports frame overruns and renderer hangs. Sits between the frame-rate divider and the renderer; its plot output drives the VGA adapter write enable.

Parameters:
- TIMEOUT, 307216, max cycles any single phase may last before it is aborted (640*480 + margin).
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- enable  in  1  global run enable (pause when low)
- frameTick  in  1  one-cycle frame strobe
- scored  in  1  lhs_scored OR rhs_scored level from movement control
- done_clearOld  in  1  renderer finished clearing old box
- done_drawNew  in  1  renderer finished drawing new box
- done_blackScreen  in  1  renderer finished full-screen clear
- clearOld_pulse  out  1  clear phase active (level)
- drawNew_pulse  out  1  draw phase active (level)
- blackScreen_pulse  out  1  black phase active (level)
- plot  out  1  VGA write enable, high whenever any phase level is high
- frame_done  out  1  one-cycle strobe on completing a draw or black pass
- busy  out  1  state != S_IDLE
- overrun_count  out  OVR_W  frame ticks dropped while busy, saturating
- timeout_err  out  1  sticky, set on any phase timeout

Behaviour:
- Reset (resetn low at clk edge): all outputs 0, overrun_count 0, timeout_err 0, score_pending 0, phase counter 0.
- The first edge with resetn high enters S_BLACK. A black pass always follows reset.
- States:
  - S_IDLE: no phase level asserted.
    - frameTick & enable & score_pending -> S_BLACK.
    - frameTick & enable & !score_pending -> S_CLEAR.
    - frameTick & !enable -> ignored, not counted.
  - S_CLEAR: clearOld_pulse=1. done_clearOld -> S_DRAW.
  - S_DRAW: drawNew_pulse=1. done_drawNew -> S_IDLE with frame_done=1 for one cycle.
  - S_BLACK: blackScreen_pulse=1; score_pending cleared on entry. done_blackScreen -> S_IDLE with frame_done=1.
- Phase levels are registered and change only on state transitions.
  - Exactly one level is high in CLEAR, DRAW or BLACK.
  - CLEAR->DRAW is back-to-back: clearOld_pulse falls and drawNew_pulse rises on the same edge.
- Done qualification:
  - Done flags are ignored in the first cycle of a phase (phase counter == 0), so stale done from the prior phase cannot end a new one. Minimum phase length is 2 cycles.
  - Only the done flag matching the current phase is honoured; the others are ignored.
- Score latch:
  - scored high in any cycle sets score_pending. This includes mid-phase and while !enable.
  - If scored is still high on the S_BLACK entry edge, pending stays clear. It re-sets only if scored is seen again afterwards.
  - A goal during CLEAR/DRAW lets the current pass finish, then the next frameTick goes to S_BLACK.
- Overrun: frameTick while busy and enable -> overrun_count+1, saturating at 2^OVR_W-1. The tick is dropped and no queueing occurs.
- Pause: enable low mid-phase -> state, phase level and phase counter all hold, and done flags are ignored. Resume continues the same phase.
- Timeout:
  - Phase counter increments each enabled cycle in a phase and clears on every transition.
  - If it reaches TIMEOUT-1 without a qualified done: timeout_err<=1 (sticky until reset) and the phase is aborted to S_IDLE.
  - An aborted phase gives no frame_done. An aborted S_BLACK re-sets score_pending.
- Simultaneous events:
  - Done and timeout on the same cycle -> done wins, no error.
  - frameTick on the same cycle as the DRAW->IDLE transition -> counts as overrun (still busy that cycle).
- Counter width is $clog2(TIMEOUT)+1. Compare is unsigned; no wrap is possible because the counter clears at the limit.

Decomposition:
- Package render_pkg holds:
  - state localparams S_IDLE=2'd0, S_CLEAR=2'd1, S_DRAW=2'd2, S_BLACK=2'd3.
  - SCREEN_X/SCREEN_Y defaults.
  - DEFAULT_TIMEOUT.
- One sub-module, phase_timer (parameter LIMIT):
  - inputs clk, resetn, clear, run.
  - outputs first (count==0) and expired (count==LIMIT-1).
- The FSM, score latch and overrun counter stay in render_sequencer.

Test Plan:
- Reset then release, done_blackScreen asserted 5 cycles later -> blackScreen_pulse high 5 cycles, then frame_done=1 one cycle, busy=0.
- frameTick in IDLE, done_clearOld after 16 cycles, done_drawNew after 16 more -> clearOld 16 cycles, drawNew 16 cycles, frame_done once, plot high 32 cycles contiguous.
- done_drawNew held high continuously, frameTick -> CLEAR is not ended early; DRAW lasts exactly 2 cycles (stale-done guard).
- Pulse scored during DRAW, then next frameTick -> current pass completes normally, next pass is S_BLACK, score_pending cleared.
- 3 frameTicks during a 100-cycle CLEAR, with TIMEOUT=1000 -> overrun_count=3; 300 ticks while busy -> count saturates at 255.
- TIMEOUT=8, no done in CLEAR -> abort to IDLE after 8 cycles, timeout_err=1 and stays 1; enable low for 20 cycles mid-phase -> counter frozen, no timeout.
